// File: rtl/dfx_seq_pkg.sv
// Shared types and helpers for the DFX RM shutdown sequencer and related WB bridges.
package dfx_seq_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    SHUTDOWN = 2'd2
  } seq_state_e;

  localparam int OUTST_W_DEF = 4;

  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_outstanding_ctr.sv
// Counts pipelined WB transactions in flight; saturates at both ends.
module wb_outstanding_ctr
  import dfx_seq_pkg::*;
#(
  parameter int W = OUTST_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue,
  input  logic         retire,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         full
);

  assign zero = (count == '0);
  assign full = (count == {W{1'b1}});

  // Retiring at zero is ignored so late responses cannot underflow the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({issue & ~full, retire & ~zero})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dfx_rm_shutdown_sequencer.sv
// Wishbone shutdown/decouple sequencer for the VS0 reconfigurable partition.
// Optional drain timeout is enabled with DFX_SEQ_DRAIN_TIMEOUT_EN.
//   state    | meaning
//   RUN      | pass-through (error-terminates while rm_decouple is high)
//   DRAIN    | new requests stalled, waiting for outstanding RM responses
//   SHUTDOWN | shutdown acknowledged, upstream error-terminated, RM isolated
module dfx_rm_shutdown_sequencer
  import dfx_seq_pkg::*;
#(
  parameter int ADR_W         = 28,
  parameter int OUTST_W       = OUTST_W_DEF,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rm_shutdown_req,
  input  logic             rm_decouple,
  output logic             rm_shutdown_ack,
  input  logic [ADR_W-1:0] wbs_adr,
  input  logic [31:0]      wbs_dat_w,
  input  logic [3:0]       wbs_sel,
  input  logic             wbs_we,
  input  logic             wbs_cyc,
  input  logic             wbs_stb,
  output logic [31:0]      wbs_dat_r,
  output logic             wbs_ack,
  output logic             wbs_err,
  output logic             wbs_stall,
  output logic [ADR_W-1:0] wbm_adr,
  output logic [31:0]      wbm_dat_w,
  output logic [3:0]       wbm_sel,
  output logic             wbm_we,
  output logic             wbm_cyc,
  output logic             wbm_stb,
  input  logic [31:0]      wbm_dat_r,
  input  logic             wbm_ack,
  input  logic             wbm_err,
  input  logic             wbm_stall,
  input  logic             rm_irq_i,
  output logic             rm_irq_o,
  output logic             drain_timeout
);

  seq_state_e state, state_next;
  logic [OUTST_W-1:0] outst_count;
  logic outst_zero, outst_full;
  logic issue, retire, drained, err_mode, err_q, tmo_fire, timer_hit;

  assign issue    = wbm_stb & ~wbm_stall;
  assign retire   = wbm_ack | wbm_err;
  assign err_mode = (state == SHUTDOWN) | ((state == RUN) & rm_decouple);
  // Drained as of the next edge, so completion is seen in the same cycle as the last response.
  assign drained  = ~wbs_cyc | outst_zero | ((outst_count == OUTST_W'(1)) & retire);
  assign rm_irq_o = rm_irq_i & ~((state != RUN) | rm_decouple);

  assign wbm_adr   = wbs_adr;
  assign wbm_dat_w = wbs_dat_w;
  assign wbm_sel   = wbs_sel;
  assign wbm_we    = wbs_we;

  wb_outstanding_ctr #(.W(OUTST_W)) u_outst (
    .clk    (clk),
    .rst    (rst),
    .issue  (issue),
    .retire (retire),
    .clear  (~wbs_cyc | tmo_fire),
    .count  (outst_count),
    .zero   (outst_zero),
    .full   (outst_full)
  );

`ifdef DFX_SEQ_DRAIN_TIMEOUT_EN
  localparam int TMR_W = timer_w(DRAIN_TIMEOUT);
  logic [TMR_W-1:0] drain_tmr;

  assign timer_hit = (drain_tmr == TMR_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_tmr     <= '0;
      drain_timeout <= 1'b0;
    end else begin
      drain_tmr <= (state == DRAIN) ? drain_tmr + 1'b1 : '0;
      if (tmo_fire)
        drain_timeout <= 1'b1;
      else if ((state == DRAIN) && (state_next == SHUTDOWN))
        drain_timeout <= 1'b0;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (DRAIN_TIMEOUT > 0);
  assign timer_hit      = 1'b0;
  assign drain_timeout  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      rm_shutdown_ack <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state           <= state_next;
      rm_shutdown_ack <= (state_next == SHUTDOWN);
      err_q           <= err_mode & wbs_cyc & wbs_stb;
    end
  end

  always_comb begin
    state_next = state;
    tmo_fire   = 1'b0;
    wbm_cyc    = 1'b0;
    wbm_stb    = 1'b0;
    wbs_stall  = 1'b1;
    wbs_ack    = 1'b0;
    wbs_err    = err_q;
    wbs_dat_r  = '0;
    case (state)
      RUN: begin
        if (rm_shutdown_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (!rm_shutdown_req) state_next = RUN;
        else if (drained) state_next = SHUTDOWN;
        else if (timer_hit) begin
          state_next = SHUTDOWN;
          tmo_fire   = 1'b1;
        end
      end
      SHUTDOWN: begin
        if (!rm_shutdown_req && !rm_decouple) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    if (err_mode) begin
      wbs_stall = 1'b0;
    end else if (state == RUN) begin
      wbm_cyc   = wbs_cyc;
      wbm_stb   = wbs_stb & ~outst_full;
      wbs_stall = wbm_stall | outst_full;
      wbs_ack   = wbm_ack;
      wbs_err   = err_q | wbm_err;
      wbs_dat_r = wbm_dat_r;
    end else begin
      wbm_cyc   = wbs_cyc & ~outst_zero;
      wbs_ack   = wbm_ack;
      wbs_err   = err_q | wbm_err;
      wbs_dat_r = wbm_dat_r;
    end
  end

endmodule
